// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential 4-digit BCD to binary converter.
// Reverse double-dabble, one bit per clock. A conversion always takes BW
// iterations, and start/busy/done form the handshake with the control FSM.
module bcd2bin_seq #(
  parameter int BW    = 14,
  parameter int LIMIT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    BCD_0,
  input  logic [3:0]    BCD_1,
  input  logic [3:0]    BCD_2,
  input  logic [3:0]    BCD_3,
  output logic [BW-1:0] B,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          err
);

  localparam int SRW = 16 + BW;                    // {d3,d2,d1,d0,bin}
  localparam logic [3:0]    CNT_LAST = 4'(BW - 1);
  localparam logic [BW-1:0] LIMIT_W  = BW'(LIMIT);

  typedef enum logic [0:0] {IDLE, SHIFT} state_e;

  state_e         state_q, state_d;
  logic [SRW-1:0] sr_q, sr_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           errin_q, errin_d;
  logic [BW-1:0]  b_q, b_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  logic [SRW-1:0] step;
  logic           dig_bad;

  // A digit is illegal when it is above 9; this is sampled with start.
  assign dig_bad = (BCD_0 > 4'd9) | (BCD_1 > 4'd9) |
                   (BCD_2 > 4'd9) | (BCD_3 > 4'd9);

  // One iteration: shift right, then subtract 3 from every digit field >= 8.
  // The correction is 4-bit modulo, so no carry crosses a field boundary.
  always_comb begin
    step = sr_q >> 1;
    for (int i = 0; i < 4; i++) begin
      if (step[BW+4*i +: 4] >= 4'd8)
        step[BW+4*i +: 4] = step[BW+4*i +: 4] - 4'd3;
    end
  end

  // Next-state and datapath updates; outputs hold unless a conversion ends.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    errin_d = errin_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {BCD_3, BCD_2, BCD_1, BCD_0, {BW{1'b0}}};
          errin_d = dig_bad;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          // An illegal digit yields 0; overflow is only reported for legal input.
          b_d     = errin_q ? '0 : step[BW-1:0];
          ovf_d   = !errin_q && (step[BW-1:0] > LIMIT_W);
          err_d   = errin_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      errin_q <= 1'b0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      errin_q <= errin_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign B    = b_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule
